// File: rtl/writeback_arbiter_pkg.sv
// ============================================================================
// Module : pa_pkg
// Brief  : Shared widths, write-back entry type and source encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pa_pkg;

    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;
    localparam int WB_DEPTH  = 4;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

endpackage

`default_nettype wire

// File: rtl/writeback_arbiter_if.sv
// ============================================================================
// Module : writeback_arbiter_if
// Brief  : Result-source handshakes and register-file write port bundle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface writeback_arbiter_if
    import pa_pkg::*;
#(
    parameter int N     = REG_IDX_W,
    parameter int WIDTH = XLEN,
    parameter int DEPTH = WB_DEPTH
);

    logic                       alu_valid;
    logic                       alu_ready;
    logic [N-1:0]               alu_rd;
    logic [WIDTH-1:0]           alu_data;
    logic                       mem_valid;
    logic                       mem_ready;
    logic [N-1:0]               mem_rd;
    logic [WIDTH-1:0]           mem_data;
    logic                       stall;
    logic                       wenable;
    logic [N-1:0]               reg_in;
    logic [WIDTH-1:0]           din;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output stall,
        input  alu_ready, mem_ready,
        input  wenable, reg_in, din, count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  stall,
        output alu_ready, mem_ready,
        output wenable, reg_in, din, count
    );

endinterface

`default_nettype wire

// File: rtl/writeback_arbiter_fifo.sv
// ============================================================================
// Module : wb_fifo
// Brief  : Synchronous push/pop FIFO of write-back entries with occupancy.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wb_fifo
    import pa_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_push,
    input  wire wb_entry_t              i_data,
    input  wire logic                   i_pop,
    output wb_entry_t                   o_head,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic                        o_full,
    output logic                        o_empty
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    wb_entry_t          r_mem [DEPTH];
    logic [c_PW-1:0]    r_wptr;
    logic [c_PW-1:0]    r_rptr;
    logic [c_CW-1:0]    r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == c_CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rptr];
    assign o_count   = r_count;

    // Payload storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/writeback_arbiter.sv
// ============================================================================
// Module : writeback_arbiter
// Brief  : Round-robin ALU/load result arbiter feeding a buffered RF write port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module writeback_arbiter
    import pa_pkg::*;
#(
    parameter int N     = REG_IDX_W,
    parameter int WIDTH = XLEN,
    parameter int DEPTH = WB_DEPTH
) (
    input  wire logic           clk,
    input  wire logic           rst,
    writeback_arbiter_if.slave  bus
);

    wb_src_e                    r_last_grant;
    logic                       w_sel_alu;
    logic                       w_sel_mem;
    logic                       w_can_accept;
    logic                       w_alu_ready;
    logic                       w_mem_ready;
    logic                       w_xfer;
    logic [N-1:0]               w_rd;
    logic [WIDTH-1:0]           w_data;
    logic                       w_push;
    logic                       w_wen;
    wb_entry_t                  w_entry;
    wb_entry_t                  w_head;
    logic [$clog2(DEPTH):0]     w_count;
    logic                       w_full;
    logic                       w_empty;

    // On a tie the source that did not win the previous transfer is chosen.
    assign w_sel_mem    = bus.mem_valid && (!bus.alu_valid || (r_last_grant == SRC_ALU));
    assign w_sel_alu    = bus.alu_valid && !w_sel_mem;
    // Readies are held low throughout reset, not just after it.
    assign w_can_accept = rst && !w_full;
    assign w_alu_ready  = w_sel_alu && w_can_accept;
    assign w_mem_ready  = w_sel_mem && w_can_accept;
    assign w_xfer       = w_alu_ready || w_mem_ready;

    assign w_rd    = w_mem_ready ? bus.mem_rd   : bus.alu_rd;
    assign w_data  = w_mem_ready ? bus.mem_data : bus.alu_data;
    assign w_push  = w_xfer && (w_rd != '0);
    assign w_entry = '{rd: REG_IDX_W'(w_rd), data: XLEN'(w_data)};

    assign w_wen = !w_empty && !bus.stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= SRC_MEM;
        end else if (w_xfer) begin
            r_last_grant <= w_mem_ready ? SRC_MEM : SRC_ALU;
        end
    end

    wb_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (w_wen),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.alu_ready = w_alu_ready;
    assign bus.mem_ready = w_mem_ready;
    assign bus.wenable   = w_wen;
    assign bus.reg_in    = w_empty ? '0 : N'(w_head.rd);
    assign bus.din       = w_empty ? '0 : WIDTH'(w_head.data);
    assign bus.count     = w_count;

endmodule

`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
// ============================================================================
// Module : tb_writeback_arbiter
// Brief  : Directed vector bench for the write-back arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_writeback_arbiter;

    logic clk;
    logic rst;

    writeback_arbiter_if #(.N(5), .WIDTH(32), .DEPTH(4)) bus ();

    writeback_arbiter #(
        .N     (5),
        .WIDTH (32),
        .DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        st;
        logic        ear;
        logic        emr;
        logic        ewen;
        logic [4:0]  ereg;
        logic [31:0] edin;
        logic [2:0]  ecnt;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_bad;

    task automatic add(input int av, input int ard, input int ad,
                       input int mv, input int mrd, input int md, input int st,
                       input int ear, input int emr, input int ewen,
                       input int ereg, input int edin, input int ecnt);
        vec_t v;
        v.av = 1'(av);   v.ard = 5'(ard);  v.ad = 32'(ad);
        v.mv = 1'(mv);   v.mrd = 5'(mrd);  v.md = 32'(md);
        v.st = 1'(st);
        v.ear = 1'(ear); v.emr = 1'(emr);  v.ewen = 1'(ewen);
        v.ereg = 5'(ereg); v.edin = 32'(edin); v.ecnt = 3'(ecnt);
        vecs.push_back(v);
    endtask

    task automatic idle(input int ewen, input int ereg, input int edin, input int ecnt);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, ewen, ereg, edin, ecnt);
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         input logic st);
        bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
        bus.mem_valid = mv; bus.mem_rd = mrd; bus.mem_data = md;
        bus.stall     = st;
    endtask

    task automatic check(input string nm, input logic ear, input logic emr, input logic ewen,
                         input logic [4:0] ereg, input logic [31:0] edin, input logic [2:0] ecnt);
        n_cmp++;
        if ({bus.alu_ready, bus.mem_ready, bus.wenable, bus.reg_in, bus.din, bus.count}
            !== {ear, emr, ewen, ereg, edin, ecnt}) begin
            n_bad++;
            $display("FAIL %s: got ar=%0b mr=%0b wen=%0b reg=%0d din=%0h cnt=%0d, want ar=%0b mr=%0b wen=%0b reg=%0d din=%0h cnt=%0d",
                     nm, bus.alu_ready, bus.mem_ready, bus.wenable, bus.reg_in, bus.din, bus.count,
                     ear, emr, ewen, ereg, edin, ecnt);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // Round-robin tie: ALU first after reset, then alternate
        add(1, 1, 101, 1, 11, 211, 0,  1, 0, 0, 0, 0, 0);
        add(1, 2, 102, 1, 11, 211, 0,  0, 1, 1, 1, 101, 1);
        add(1, 2, 102, 1, 12, 212, 0,  1, 0, 1, 11, 211, 1);
        add(1, 3, 103, 1, 12, 212, 0,  0, 1, 1, 2, 102, 1);
        idle(1, 12, 212, 1);
        idle(0, 0, 0, 0);
        // Single ALU write, one-cycle latency, exactly one write cycle
        add(1, 15, 2047, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        idle(1, 15, 2047, 1);
        idle(0, 0, 0, 0);
        // r0 load is acknowledged but discarded
        add(0, 0, 0, 1, 0, 'hFFFF, 0,  0, 1, 0, 0, 0, 0);
        idle(0, 0, 0, 0);
        idle(0, 0, 0, 0);
        // Stall fills the FIFO; full blocks the 5th push until a pop lands
        add(1, 1, 101, 0, 0, 0, 1,     1, 0, 0, 0, 0, 0);
        add(1, 2, 102, 0, 0, 0, 1,     1, 0, 0, 1, 101, 1);
        add(1, 3, 103, 0, 0, 0, 1,     1, 0, 0, 1, 101, 2);
        add(1, 4, 104, 0, 0, 0, 1,     1, 0, 0, 1, 101, 3);
        add(1, 5, 105, 0, 0, 0, 1,     0, 0, 0, 1, 101, 4);
        add(1, 5, 105, 0, 0, 0, 1,     0, 0, 0, 1, 101, 4);
        add(1, 5, 105, 0, 0, 0, 0,     0, 0, 1, 1, 101, 4);
        add(1, 5, 105, 0, 0, 0, 0,     1, 0, 1, 2, 102, 3);
        idle(1, 3, 103, 3);
        idle(1, 4, 104, 2);
        idle(1, 5, 105, 1);
        idle(0, 0, 0, 0);
        // Concurrent push/pop at count 2 across the pointer wrap
        add(1, 6, 106, 0, 0, 0, 1,     1, 0, 0, 0, 0, 0);
        add(1, 7, 107, 0, 0, 0, 1,     1, 0, 0, 6, 106, 1);
        add(1, 8, 108, 0, 0, 0, 0,     1, 0, 1, 6, 106, 2);
        add(0, 0, 0, 1, 9, 209, 0,     0, 1, 1, 7, 107, 2);
        add(1, 10, 110, 0, 0, 0, 0,    1, 0, 1, 8, 108, 2);
        idle(1, 9, 209, 2);
        idle(1, 10, 110, 1);
        idle(0, 0, 0, 0);

        // Reset with both sources requesting: readies and outputs stay low
        rst = 1'b0;
        drive(1, 3, 33, 1, 4, 44, 0);
        @(negedge clk);
        @(negedge clk);
        check("reset_state", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].mv, vecs[i].mrd, vecs[i].md, vecs[i].st);
            #2;
            check($sformatf("vec%0d", i), vecs[i].ear, vecs[i].emr, vecs[i].ewen,
                  vecs[i].ereg, vecs[i].edin, vecs[i].ecnt);
            @(negedge clk);
        end

        // Mid-operation reset discards three buffered entries
        for (int k = 0; k < 3; k++) begin
            drive(1, 5'(20 + k), 32'(120 + k), 0, 0, 0, 1);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        check("pre_reset", 0, 0, 1, 20, 120, 3);
        drive(1, 9, 99, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        check("async_reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("held_reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #2;
            check($sformatf("post_reset%0d", k), 0, 0, 0, 0, 0, 0);
            @(negedge clk);
        end

        // Tie immediately after reset favours the ALU again
        drive(1, 1, 101, 1, 2, 202, 0);
        #2;
        check("tie_after_reset", 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        check("tie_after_reset_wr", 0, 0, 1, 1, 101, 1);
        @(negedge clk);
        #2;
        check("tie_after_reset_idle", 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter N, 5, register index width.
REQ-002 Parameter WIDTH, 32, data width.
REQ-003 Parameter DEPTH, 4, writeback FIFO entries (power of two, >= 2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 alu_valid, alu_ready  input/output  1 each  ALU result handshake.
REQ-007 alu_rd  input  N  and  alu_data  input  WIDTH  ALU destination register and result.
REQ-008 mem_valid, mem_ready  input/output  1 each  memory-load result handshake.
REQ-009 mem_rd  input  N  and  mem_data  input  WIDTH  load destination register and result.
REQ-010 stall  input  1  holds the register-file write port; no write while 1.
REQ-011 wenable  output  1  register-file write enable.
REQ-012 reg_in  output  N  and  din  output  WIDTH  register-file write index and data.
REQ-013 count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014 A transfer on a source occurs in a cycle where its valid and ready are both 1 at the rising edge.
REQ-015 At most one source transfers per cycle.
REQ-016 ready is 1 only for the granted source and only when count < DEPTH; the other source's ready is 0.
REQ-017 Grant: only one source valid -> that source; both valid -> the source not recorded in last_grant.
REQ-018 last_grant updates only on a completed transfer, including dropped r0 transfers.
REQ-019 A transfer with rd == 0 completes the handshake but creates no FIFO entry and never produces a write.
REQ-020 A transfer with rd != 0 pushes {rd, data} at the FIFO tail at the same clock edge.
REQ-021 wenable = (count != 0) && !stall; reg_in/din show the head entry while count != 0, else 0.
REQ-022 Pop occurs at any edge where wenable is 1; each entry produces exactly one wenable cycle.
REQ-023 Latency: an entry accepted at edge K drives wenable in the cycle after edge K when the FIFO was empty and stall is 0.
REQ-024 Writes leave strictly in acceptance order; no reordering or merging of entries with the same rd.
REQ-025 Simultaneous push and pop: count unchanged, head advances, new entry placed at tail.
REQ-026 Full (count == DEPTH): both readies 0 regardless of a pop in the same cycle; ready reasserts the cycle after count drops.
REQ-027 Empty: wenable 0 even if a push occurs in the same cycle; no combinational bypass from inputs.
REQ-028 Read and write pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-029 stall freezes head, pointers, and count apart from pushes; it does not affect the readies.

Reset
REQ-030 While rst == 0: count 0, pointers 0, last_grant = mem (ALU wins first tie), wenable 0, reg_in 0, din 0, both readies 0.
REQ-031 Reset mid-operation discards all buffered entries; no write is issued for them after release.
REQ-032 FIFO data storage needs no reset.

Structure
REQ-033 Shared package pa_pkg holds REG_IDX_W (5), XLEN (32), WB_DEPTH (4), and typedef wb_entry_t {rd, data}.
REQ-034 One sub-module, wb_fifo: synchronous push/pop FIFO of wb_entry_t with count, full and empty.
REQ-035 Arbitration, r0 filtering, and write-port drive stay in writeback_arbiter.

Verification
REQ-036 ALU only, rd=15, data=2047, stall=0 -> next cycle wenable=1, reg_in=15, din=2047 for exactly one cycle.
REQ-037 Both valid for 4 cycles after reset (ALU rd=1..4, MEM rd=11..14) -> grant order ALU1, MEM11, ALU2, MEM12; writes in that order.
REQ-038 MEM rd=0, data=0xFFFF -> mem_ready=1, count stays 0, wenable never asserts.
REQ-039 stall=1, 5 ALU pushes (rd=1..5) -> count reaches 4, alu_ready=0 on the 5th; release stall -> writes rd 1,2,3,4, then 5 after ready returns.
REQ-040 Push and pop in the same cycle at count=2 -> count remains 2; writes stay in acceptance order across pointer wrap.
REQ-041 rst driven low with count=3 -> wenable=0 immediately; after release count=0 and no stale writes appear.
